// File: rtl/multicycle_main_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait-state handshake,
// memory timeout abort and a retired-instruction counter. Define ILLEGAL_TRAP_EN to trap illegal opcodes.
module multicycle_main_control #(
  parameter int OP_W        = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  input  logic             trap_ack,
  output logic [9:0]       ctrl,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             mem_err
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [9:0]       r_ctrl;
  logic [9:0]       w_ctrl_dec;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_mem_err;
  logic [OP_W-1:0]  w_op_hi;
  logic             w_illegal;
  logic             w_retire;
  logic             w_abort;
  logic             w_timeout;

  assign w_op_hi   = op >> 4;
  assign w_timeout = (r_to_cnt == TO_W'(MEM_TIMEOUT));

  // Illegal opcodes decode to an all-zero control word.
  always_comb begin
    w_ctrl_dec = '0;
    w_illegal  = 1'b0;
    if (w_op_hi != '0) begin
      w_illegal = 1'b1;
    end else begin
      case (op[3:0])
        4'h0:    w_ctrl_dec = 10'b1001000010;
        4'h1:    w_ctrl_dec = 10'b1001000110;
        4'h2:    w_ctrl_dec = 10'b1001000000;
        4'h3:    w_ctrl_dec = 10'b1001000001;
        4'h4:    w_ctrl_dec = 10'b0101000010;
        4'h5:    w_ctrl_dec = 10'b0111000010;
        4'h6:    w_ctrl_dec = 10'b0100100010;
        4'h7:    w_ctrl_dec = 10'b1001000111;
        4'h8:    w_ctrl_dec = 10'b0000001110;
        4'h9:    w_ctrl_dec = 10'b0000010110;
        default: w_illegal  = 1'b1;
      endcase
    end
  end

`ifndef ILLEGAL_TRAP_EN
  logic w_unused;
  assign w_unused = trap_ack ^ w_illegal;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel_data  = 1'b0;
    reg_write     = 1'b0;
    w_retire      = 1'b0;
    w_abort       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          // On the timeout cycle the request survives only if ready arrives with it.
          mem_req = !w_timeout || mem_ready;
          if (mem_ready) begin
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            w_state_nxt = S_DECODE;
          end else if (w_timeout) begin
            w_abort = 1'b1;
          end
        end
        S_DECODE: begin
          w_state_nxt = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
          if (w_illegal) w_state_nxt = S_TRAP;
`endif
        end
        S_EXEC: begin
          if (r_ctrl[7] || r_ctrl[5]) begin
            w_state_nxt = S_MEM;
          end else if (r_ctrl[4] || r_ctrl[3]) begin
            pc_write_cond = 1'b1;
            w_retire      = 1'b1;
            w_state_nxt   = S_FETCH;
          end else if (r_ctrl[6]) begin
            w_state_nxt = S_WB;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req      = !w_timeout || mem_ready;
          mem_sel_data = 1'b1;
          mem_we       = mem_req && r_ctrl[5];
          if (mem_ready) begin
            if (r_ctrl[7]) begin
              w_state_nxt = S_WB;
            end else begin
              w_retire    = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end else if (w_timeout) begin
            w_abort = 1'b1;
          end
        end
        S_WB: begin
          reg_write   = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          if (trap_ack) w_state_nxt = S_FETCH;
`else
          w_state_nxt = S_FETCH;
`endif
        end
        default: w_state_nxt = S_FETCH;
      endcase
      if (w_abort) w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= '0;
      r_to_cnt  <= '0;
      r_retired <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) r_ctrl <= w_ctrl_dec;
      // An abort re-enters FETCH from FETCH, so it must clear the counter explicitly.
      if ((w_state_nxt != r_state) || w_abort) begin
        r_to_cnt <= '0;
      end else if (mem_req && !mem_ready) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_retire) r_retired <= r_retired + 1'b1;
      if (w_abort) r_mem_err <= 1'b1;
    end
  end

  assign ctrl    = r_ctrl;
  assign state   = r_state;
  assign retired = r_retired;
  assign mem_err = r_mem_err;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected records are queued
// while stimulus is generated and compared against the DUT one cycle at a time.
module tb_multicycle_main_control;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op = 4'h0;
  logic        mem_ready = 1'b0;
  logic        trap_ack = 1'b0;
  logic [9:0]  ctrl;
  logic        ir_write, pc_write, pc_write_cond, mem_req, mem_we, mem_sel_data, reg_write;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        mem_err;

  always #5 clk = ~clk;

  multicycle_main_control #(.OP_W(4), .CNT_W(16), .MEM_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .ctrl(ctrl), .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data), .reg_write(reg_write),
    .state(state), .retired(retired), .mem_err(mem_err)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic        rdy;
    logic        ack;
    logic [2:0]  st;
    logic        req, we, sel, irw, pcw, pcc, rw, err;
    logic [9:0]  ctl;
    logic [15:0] ret;
  } cyc_t;

  // strobe vectors {req, we, sel, ir_write, pc_write, pc_write_cond, reg_write}
  localparam logic [6:0] ST_NONE   = 7'b0000000;
  localparam logic [6:0] ST_F_WAIT = 7'b1000000;
  localparam logic [6:0] ST_F_RDY  = 7'b1001100;
  localparam logic [6:0] ST_BR     = 7'b0000010;
  localparam logic [6:0] ST_WB     = 7'b0000001;
  localparam logic [6:0] ST_M_LD   = 7'b1010000;
  localparam logic [6:0] ST_M_ST   = 7'b1110000;
  localparam logic [6:0] ST_M_ABT  = 7'b0010000;

  cyc_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] g_ret = '0;
  logic        g_err = 1'b0;
  logic [9:0]  g_ctl = '0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] dec(input logic [3:0] o);
    case (o)
      4'h0: return 10'b1001000010;
      4'h1: return 10'b1001000110;
      4'h2: return 10'b1001000000;
      4'h3: return 10'b1001000001;
      4'h4: return 10'b0101000010;
      4'h5: return 10'b0111000010;
      4'h6: return 10'b0100100010;
      4'h7: return 10'b1001000111;
      4'h8: return 10'b0000001110;
      4'h9: return 10'b0000010110;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic junk();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input logic [6:0] str, input logic rdy,
                      input logic ack, input logic [3:0] o);
    cyc_t c;
    c.op  = o;
    c.rdy = rdy;
    c.ack = ack;
    c.st  = st;
    {c.req, c.we, c.sel, c.irw, c.pcw, c.pcc, c.rw} = str;
    c.err = g_err;
    c.ctl = g_ctl;
    c.ret = g_ret;
    q.push_back(c);
  endtask

  task automatic gen_fetch_timeout();
    for (int i = 0; i < TO; i++) push(3'd0, ST_F_WAIT, 1'b0, junk(), 4'($urandom_range(0, 15)));
    push(3'd0, ST_NONE, 1'b0, junk(), 4'h0);
    g_err = 1'b1;
  endtask

  task automatic gen_instr(input logic [3:0] o, input int fw, input int mw);
    logic       is_lw, is_sw, is_br, legal;
    logic [6:0] ms;
    is_lw = (o == 4'h5);
    is_sw = (o == 4'h6);
    is_br = (o == 4'h8) || (o == 4'h9);
    legal = (o <= 4'h9);
    for (int i = 0; i < fw; i++) push(3'd0, ST_F_WAIT, 1'b0, junk(), 4'($urandom_range(0, 15)));
    push(3'd0, ST_F_RDY, 1'b1, junk(), 4'($urandom_range(0, 15)));
    push(3'd1, ST_NONE, junk(), junk(), o);
    g_ctl = dec(o);
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) push(3'd5, ST_NONE, junk(), 1'b0, 4'($urandom_range(0, 15)));
      push(3'd5, ST_NONE, junk(), 1'b1, 4'($urandom_range(0, 15)));
`else
      push(3'd2, ST_NONE, junk(), junk(), 4'($urandom_range(0, 15)));
      g_ret++;
`endif
      return;
    end
    if (is_br) begin
      push(3'd2, ST_BR, junk(), junk(), 4'($urandom_range(0, 15)));
      g_ret++;
      return;
    end
    push(3'd2, ST_NONE, junk(), junk(), 4'($urandom_range(0, 15)));
    if (is_lw || is_sw) begin
      ms = is_sw ? ST_M_ST : ST_M_LD;
      if (mw > TO) begin
        for (int i = 0; i < TO; i++) push(3'd3, ms, 1'b0, junk(), 4'($urandom_range(0, 15)));
        push(3'd3, ST_M_ABT, 1'b0, junk(), 4'($urandom_range(0, 15)));
        g_err = 1'b1;
        return;
      end
      for (int i = 0; i < mw; i++) push(3'd3, ms, 1'b0, junk(), 4'($urandom_range(0, 15)));
      push(3'd3, ms, 1'b1, junk(), 4'($urandom_range(0, 15)));
      if (is_sw) begin
        g_ret++;
        return;
      end
    end
    push(3'd4, ST_WB, junk(), junk(), 4'($urandom_range(0, 15)));
    g_ret++;
  endtask

  // Entered and left at posedge+1.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      op        = c.op;
      mem_ready = c.rdy;
      trap_ack  = c.ack;
      @(negedge clk);
      check_val("strobes",
                {21'd0, state, mem_req, mem_we, mem_sel_data, ir_write, pc_write,
                 pc_write_cond, reg_write, mem_err},
                {21'd0, c.st, c.req, c.we, c.sel, c.irw, c.pcw, c.pcc, c.rw, c.err});
      check_val("ctrl", {22'd0, ctrl}, {22'd0, c.ctl});
      check_val("retired", {16'd0, retired}, {16'd0, c.ret});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] alu_ops [5];
    alu_ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outs",
              {21'd0, state, mem_req, mem_we, mem_sel_data, ir_write, pc_write,
               pc_write_cond, reg_write, mem_err}, 32'd0);
    check_val("reset_ctrl", {22'd0, ctrl}, 32'd0);
    check_val("reset_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0;

    gen_instr(4'h0, 0, 0);
    gen_instr(4'h5, 1, 2);
    gen_instr(4'h6, 0, 1);
    gen_instr(4'h8, 0, 0);
    gen_instr(4'h9, 2, 0);
    for (int i = 0; i < 5; i++) gen_instr(alu_ops[i], i % 2, 0);
    gen_instr(4'hF, 0, 0);
    gen_instr(4'hA, 1, 0);
    gen_fetch_timeout();
    gen_instr(4'h0, 0, 0);
    gen_instr(4'h5, 0, TO);
    gen_instr(4'h6, 0, TO + 1);
    gen_instr(4'h7, 0, 0);
    run_queue();

    // Asynchronous reset in the middle of an instruction fetch.
    mem_ready = 1'b0;
    #1;
    check_val("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_req", {31'd0, mem_req}, 32'd0);
    check_val("async_rst_state", {29'd0, state}, 32'd0);
    check_val("async_rst_retired", {16'd0, retired}, 32'd0);
    check_val("async_rst_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    g_ret = '0;
    g_err = 1'b0;
    g_ctl = '0;
    gen_instr(4'h0, 0, 0);
    gen_instr(4'h8, 1, 0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
